// File: rtl/hour_counter.sv
// Hours stage of the clock chain: 0-23 hour register stepped by the minute carry or by the set button,
// with auto-repeat while the button is held, a day-carry pulse on counted wraps, and BCD display outputs.
module hour_counter #(
   parameter int unsigned REPEAT_DELAY = 50_000_000,
   parameter int unsigned REPEAT_RATE  = 12_500_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       min_carry,
   input  logic       set_mode,
   input  logic       inc_btn,
   input  logic       fmt_12h,
   output logic [4:0] hour,
   output logic [3:0] hour_tens,
   output logic [3:0] hour_ones,
   output logic       pm,
   output logic       carry_day
);

   // state   | meaning
   // ST_RUN  | hour advances on each minute-carry rising edge
   // ST_SET  | carries discarded; waiting for an inc_btn press
   // ST_HOLD | button held after a press; auto-repeat timing active
   typedef enum logic [1:0] {ST_RUN, ST_SET, ST_HOLD} state_t;

   state_t      state_q, state_d;
   logic [4:0]  hour_q, hour_d;
   logic        cday_q, cday_d;
   logic        carry_prev_q;
   logic        btn_prev_q;
   logic [31:0] cnt_q, cnt_d;
   logic        rep_q, rep_d;

   logic        carry_rise;
   logic        btn_rise;
   logic [4:0]  hour_step;
   logic [31:0] cnt_inc;
   logic        auto_step;
   logic [4:0]  disp;

   assign carry_rise = min_carry & ~carry_prev_q;
   assign btn_rise   = inc_btn & ~btn_prev_q;
   assign hour_step  = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
   assign cnt_inc    = cnt_q + 32'd1;
   // The first auto-step waits the long delay; rep_q marks that repeat cadence has begun.
   assign auto_step  = rep_q ? (cnt_inc == REPEAT_RATE) : (cnt_inc == REPEAT_DELAY - 32'd1);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_RUN;
         hour_q       <= 5'd0;
         cday_q       <= 1'b0;
         carry_prev_q <= 1'b1;
         btn_prev_q   <= 1'b0;
         cnt_q        <= 32'd0;
         rep_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         hour_q       <= hour_d;
         cday_q       <= cday_d;
         carry_prev_q <= min_carry;
         btn_prev_q   <= inc_btn;
         cnt_q        <= cnt_d;
         rep_q        <= rep_d;
      end
   end

   always_comb begin
      state_d = state_q;
      hour_d  = hour_q;
      cday_d  = 1'b0;
      cnt_d   = cnt_q;
      rep_d   = rep_q;
      case (state_q)
         ST_RUN: begin
            if (carry_rise) begin
               hour_d = hour_step;
               cday_d = (hour_q == 5'd23);
            end
            if (set_mode) state_d = ST_SET;
         end
         ST_SET: begin
            if (!set_mode) begin
               state_d = ST_RUN;
            end else if (btn_rise) begin
               hour_d  = hour_step;
               cnt_d   = 32'd0;
               rep_d   = 1'b0;
               state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (!set_mode) begin
               state_d = ST_RUN;
               cnt_d   = 32'd0;
            end else if (!inc_btn) begin
               state_d = ST_SET;
               cnt_d   = 32'd0;
            end else if (auto_step) begin
               hour_d = hour_step;
               cnt_d  = 32'd0;
               rep_d  = 1'b1;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   // 12 h mode shows midnight and noon as 12.
   always_comb begin
      disp = hour_q;
      if (fmt_12h) begin
         if (hour_q == 5'd0 || hour_q == 5'd12) disp = 5'd12;
         else if (hour_q > 5'd12)               disp = hour_q - 5'd12;
      end
      if (disp >= 5'd20) begin
         hour_tens = 4'd2;
         hour_ones = 4'(disp - 5'd20);
      end else if (disp >= 5'd10) begin
         hour_tens = 4'd1;
         hour_ones = 4'(disp - 5'd10);
      end else begin
         hour_tens = 4'd0;
         hour_ones = 4'(disp);
      end
   end

   assign hour      = hour_q;
   assign pm        = (hour_q >= 5'd12);
   assign carry_day = cday_q;

endmodule

// File: tb/tb_hour_counter.sv
// Bench for hour_counter: directed scenarios plus random stimulus, compared every cycle against
// an arithmetic reference model of the hour/set/auto-repeat rules.
module tb_hour_counter;
   localparam int RD = 4;
   localparam int RR = 2;

   logic       clk = 1'b0;
   logic       reset, min_carry, set_mode, inc_btn, fmt_12h;
   logic [4:0] hour;
   logic [3:0] hour_tens, hour_ones;
   logic       pm, carry_day;

   int checks = 0;
   int errors = 0;
   int cday_count = 0;

   // reference model state: mode 0 run, 1 set, 2 held; m_held counts cycles since the press
   int m_hour, m_cday, m_prevc, m_prevb, m_mode, m_held;

   always #5 clk = ~clk;

   hour_counter #(.REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut (
      .clk(clk), .reset(reset), .min_carry(min_carry), .set_mode(set_mode),
      .inc_btn(inc_btn), .fmt_12h(fmt_12h), .hour(hour), .hour_tens(hour_tens),
      .hour_ones(hour_ones), .pm(pm), .carry_day(carry_day)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model(input bit r, input bit mc, input bit sm, input bit b);
      bit rise;
      rise   = mc && (m_prevc == 0);
      m_cday = 0;
      if (r) begin
         m_hour = 0; m_mode = 0; m_prevc = 1; m_prevb = 0; m_held = 0;
      end else begin
         case (m_mode)
            0: begin
               if (rise) begin
                  m_cday = (m_hour == 23) ? 1 : 0;
                  m_hour = (m_hour + 1) % 24;
               end
               if (sm) m_mode = 1;
            end
            1: begin
               if (!sm) m_mode = 0;
               else if (b && m_prevb == 0) begin
                  m_hour = (m_hour + 1) % 24;
                  m_held = 0;
                  m_mode = 2;
               end
            end
            default: begin
               if (!sm) m_mode = 0;
               else if (!b) m_mode = 1;
               else begin
                  m_held++;
                  if (m_held >= RD - 1 && (m_held - (RD - 1)) % RR == 0)
                     m_hour = (m_hour + 1) % 24;
               end
            end
         endcase
         m_prevc = mc ? 1 : 0;
         m_prevb = b ? 1 : 0;
      end
   endtask

   task automatic cyc(input bit r, input bit mc, input bit sm, input bit b, input bit f);
      int d;
      reset = r; min_carry = mc; set_mode = sm; inc_btn = b; fmt_12h = f;
      model(r, mc, sm, b);
      @(posedge clk);
      #1;
      if (carry_day === 1'b1) cday_count++;
      d = m_hour;
      if (f) d = (m_hour % 12 == 0) ? 12 : m_hour % 12;
      check("hour", hour, m_hour);
      check("carry_day", carry_day, m_cday);
      check("tens", hour_tens, d / 10);
      check("ones", hour_ones, d % 10);
      check("pm", pm, (m_hour >= 12) ? 1 : 0);
   endtask

   task automatic goto_hour(input int h);
      cyc(1, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      for (int i = 0; i < h; i++) begin
         cyc(0, 1, 0, 0, 0);
         cyc(0, 0, 0, 0, 0);
      end
   endtask

   initial begin
      int exp_hold[10];
      bit mc, sm, b;
      exp_hold = '{6, 6, 6, 7, 7, 8, 8, 9, 9, 10};

      // reset with the carry held high, then release while it stays high
      cday_count = 0;
      for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, 0);
      for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 0);
      check("held_carry_hour", hour, 0);
      check("held_carry_cday", cday_count, 0);

      // a full day of 3-cycle carry levels
      cyc(0, 0, 0, 0, 0);
      cday_count = 0;
      for (int i = 1; i <= 24; i++) begin
         for (int k = 0; k < 3; k++) cyc(0, 1, 0, 0, 1'($urandom % 2));
         check("day_step", hour, i % 24);
         cyc(0, 0, 0, 0, 1'($urandom % 2));
      end
      check("day_cday_count", cday_count, 1);

      // display formats
      goto_hour(13);
      cyc(0, 0, 0, 0, 1);
      check("d13_12h_tens", hour_tens, 0);
      check("d13_12h_ones", hour_ones, 1);
      check("d13_pm", pm, 1);
      cyc(0, 0, 0, 0, 0);
      check("d13_24h_tens", hour_tens, 1);
      check("d13_24h_ones", hour_ones, 3);
      goto_hour(0);
      cyc(0, 0, 0, 0, 1);
      check("d0_12h", {hour_tens, hour_ones, 3'b0, pm}, {4'd1, 4'd2, 4'd0});
      goto_hour(12);
      cyc(0, 0, 0, 0, 1);
      check("d12_12h", {hour_tens, hour_ones, 3'b0, pm}, {4'd1, 4'd2, 4'd1});

      // set mode stepping through the day wrap
      goto_hour(22);
      cday_count = 0;
      cyc(0, 0, 1, 0, 0);
      for (int p = 0; p < 3; p++) begin
         cyc(0, 0, 1, 1, 0);
         cyc(0, 0, 1, 1, 0);
         cyc(0, 0, 1, 0, 0);
         cyc(0, 1, 1, 0, 0);
         cyc(0, 0, 1, 0, 0);
         check("set_press", hour, (23 + p) % 24);
      end
      check("set_no_cday", cday_count, 0);

      // auto-repeat
      goto_hour(5);
      cyc(0, 0, 1, 0, 0);
      for (int i = 0; i < 10; i++) begin
         cyc(0, 0, 1, 1, 0);
         check("hold_seq", hour, exp_hold[i]);
      end
      for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0);
      check("hold_release", hour, 10);

      // leave HOLD with a simultaneous carry edge
      goto_hour(8);
      cyc(0, 0, 1, 0, 0);
      cyc(0, 0, 1, 1, 0);
      cyc(0, 0, 1, 1, 0);
      check("hold_at9", hour, 9);
      cyc(0, 1, 0, 1, 0);
      check("exit_discard", hour, 9);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0);
      check("exit_next_carry", hour, 10);

      // reset in the middle of HOLD returns to RUN
      cyc(0, 0, 1, 0, 0);
      cyc(0, 0, 1, 1, 0);
      cyc(0, 0, 1, 1, 0);
      cyc(1, 0, 1, 1, 0);
      check("hold_reset", hour, 0);
      cyc(0, 0, 0, 1, 0);
      cyc(0, 1, 0, 1, 0);
      check("reset_run", hour, 1);

      // random traffic
      mc = 0; sm = 0; b = 0;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom % 3 == 0)  mc = ~mc;
         if ($urandom % 40 == 0) sm = ~sm;
         if ($urandom % 8 == 0)  b  = ~b;
         cyc(1'($urandom % 500 == 0), mc, sm, b, 1'($urandom % 2));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
